// File: rtl/mult_hilo_if.sv
// Bundle of execute-stage request, multiplier and HI/LO result signals for mult_hilo_unit.
// The master side issues requests and returns the multiplier product; the slave side is the unit.
interface mult_hilo_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        rd_req;
  logic [1:0]  mult_op;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op, op_a, op_b, mthi, mtlo, wdata, rd_req, product_hi, product_lo,
    input  mult_op, mult_a, mult_b, hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, op_a, op_b, mthi, mtlo, wdata, rd_req, product_hi, product_lo,
    output mult_op, mult_a, mult_b, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mult_hilo_unit.sv
// HI/LO control stage: registers multiplier operands, waits LATENCY cycles, captures the
// 64-bit product into HI/LO, services MTHI/MTLO and stalls HI/LO accesses during a multiply.
module mult_hilo_unit #(
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_hilo_if.slave    bus
);

  typedef enum logic {IDLE, BUSY} stateT;

  stateT       stateReg;
  stateT       stateNext;
  logic [3:0]  cntReg;
  logic [1:0]  multOpReg;
  logic [31:0] multAReg;
  logic [31:0] multBReg;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        doneReg;
  logic        accept;
  logic        capture;
  logic        busy;

  assign busy = (stateReg == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    accept    = 1'b0;
    capture   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (cntReg == 4'd1) begin
          capture   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Counter reaches 0 on the capture edge and then holds, since it only reloads on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntReg    <= 4'd0;
      multOpReg <= 2'b00;
      multAReg  <= 32'd0;
      multBReg  <= 32'd0;
      doneReg   <= 1'b0;
    end else begin
      doneReg <= capture;
      if (accept) begin
        cntReg    <= 4'(LATENCY);
        multOpReg <= bus.op;
        multAReg  <= bus.op_a;
        multBReg  <= bus.op_b;
      end else if (busy) begin
        cntReg <= cntReg - 4'd1;
      end
    end
  end

  // A start in IDLE wins over MTHI/MTLO; the write is dropped and the requester retries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiReg <= 32'd0;
      loReg <= 32'd0;
    end else if (capture) begin
      hiReg <= bus.product_hi;
      loReg <= bus.product_lo;
    end else if (!busy && !bus.start) begin
      if (bus.mthi) hiReg <= bus.wdata;
      if (bus.mtlo) loReg <= bus.wdata;
    end
  end

  assign bus.stall   = (busy & (bus.start | bus.mthi | bus.mtlo | bus.rd_req))
                     | (~busy & bus.start & (bus.mthi | bus.mtlo));
  assign bus.mult_op = multOpReg;
  assign bus.mult_a  = multAReg;
  assign bus.mult_b  = multBReg;
  assign bus.hi      = hiReg;
  assign bus.lo      = loReg;
  assign bus.busy    = busy;
  assign bus.done    = doneReg;

endmodule

// File: doc/mult_hilo_unit.md
# mult_hilo_unit

Control and storage stage that wraps the combinational 32x32 multiplier (multU). It accepts multiply requests from the execute stage, registers the operands and op code that drive the multiplier, waits a fixed settle latency, then captures the 64-bit product into the architectural HI/LO registers. It also services MTHI/MTLO writes and raises a stall for any HI/LO access that arrives while a multiply is in flight.

## Interface
Parameters:
- LATENCY, 4, cycles from start acceptance to HI/LO capture; legal range 1..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  multiply request (MULT/MULTU issue).
- op  in  2  multiplier op code, forwarded unchanged (2'b10 unsigned, 2'b11 signed).
- op_a  in  32  first operand (rs).
- op_b  in  32  second operand (rt).
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  32  MTHI/MTLO data.
- rd_req  in  1  MFHI/MFLO in decode this cycle.
- mult_op  out  2  registered op code driving the multiplier.
- mult_a  out  32  registered operand A driving the multiplier.
- mult_b  out  32  registered operand B driving the multiplier.
- product_hi  in  32  multiplier upper result.
- product_lo  in  32  multiplier lower result.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  multiply in flight.
- done  out  1  one-cycle pulse after HI/LO capture.
- stall  out  1  combinational; requester must hold its request.

## Operation
- Two states: IDLE (busy=0) and BUSY (busy=1). A 4-bit down-counter tracks the remaining cycles.
- IDLE with start=1: latch op/op_a/op_b into mult_op/mult_a/mult_b, load counter with LATENCY, go BUSY.
- BUSY: decrement the counter each edge. At the edge where the counter equals 1:
  - hi<=product_hi, lo<=product_lo.
  - busy<=0, done<=1, go IDLE.
- mult_* outputs hold their values until the next accepted start. They do not clear on completion.
- IDLE without start: mthi writes hi and mtlo writes lo at the edge. Both may be asserted together, in which case both registers take wdata.
- Priority and stall:
  - stall = busy & (start | mthi | mtlo | rd_req) | (~busy & start & (mthi | mtlo)).
  - In IDLE, start beats MTHI/MTLO in the same cycle. The write is dropped and stall is asserted so the requester retries; the retry then stalls until completion.
  - In BUSY, start, mthi and mtlo are ignored. No state changes.
- hi/lo always present the current register contents. During BUSY they show the pre-multiply values.
- rd_req has no side effect other than stall.
- Reset (rst_n low, at any time including mid-multiply):
  - hi, lo, mult_op, mult_a, mult_b, the counter, busy and done clear to 0 immediately. The FSM goes to IDLE.
  - An in-flight multiply is abandoned with no capture.

## Timing
- start sampled at edge E0 → busy=1 from E0 through edge E0+LATENCY.
- product_hi/lo sampled at edge E0+LATENCY. The multiplier therefore has LATENCY full cycles to settle from registered operands.
- hi/lo valid and done=1 in the cycle after E0+LATENCY; done drops at the following edge.
- A new start is accepted in the same cycle done=1 (busy=0), giving back-to-back throughput of one multiply per LATENCY+1 cycles.
- LATENCY=1: busy is high for exactly one cycle.
- The counter never wraps: it is loaded only on accept and stops at capture.
- stall is purely combinational from busy and the request inputs, with no added cycle.

## Test plan
- Reset: hold rst_n=0, then release → hi=lo=0, busy=done=stall=0, mult_a=mult_b=0. Assert rst_n low at E0+2 of a multiply → busy drops immediately and hi/lo stay 0.
- Unsigned: op=2'b10, op_a=20, op_b=30, LATENCY=4 → busy for 4 edges, then hi=32'h00000000, lo=32'h00000258, done pulses once.
- Signed: op=2'b11, op_a=20, op_b=-30 → hi=32'hFFFFFFFF, lo=32'hFFFFFDA8. Check mult_op=2'b11 is held until the next start.
- Busy interlock: start, then at E0+1 assert rd_req, mthi (wdata=32'hDEAD0000) and a second start → stall=1 each cycle. hi/lo unchanged until capture, and the second multiply is not launched during busy.
- MTHI/MTLO in IDLE: mthi=mtlo=1 with wdata=32'h12345678 → hi=lo=32'h12345678 next cycle, stall=0. Same cycle as start: write dropped and stall=1.
- Back-to-back: second start in the done cycle → accepted; LATENCY=1 variant gives busy high for exactly one cycle.
